// File: rtl/fifo_level.sv
// Parametrised single-clock FIFO with occupancy count, almost-full/almost-empty flags, synchronous flush
// and a registered read port. Define FIFO_LEVEL_ERR_EN to add sticky overflow/underflow flags.
module fifo_level #(
  parameter int ADDRESS_WIDTH = 4,
  parameter int DATA_WIDTH    = 32,
  parameter int AFULL_LEVEL   = 14,
  parameter int AEMPTY_LEVEL  = 2
) (
  input  logic                    fifolvl_clk_i,
  input  logic                    fifolvl_rstn_i,
  input  logic                    fifolvl_flush_i,
  input  logic                    fifolvl_write_i,
  input  logic [DATA_WIDTH-1:0]   fifolvl_wdata_i,
  input  logic                    fifolvl_read_i,
  output logic [DATA_WIDTH-1:0]   fifolvl_rdata_o,
  output logic                    fifolvl_rvalid_o,
  output logic                    fifolvl_full_o,
  output logic                    fifolvl_empty_o,
  output logic                    fifolvl_afull_o,
  output logic                    fifolvl_aempty_o,
  output logic [ADDRESS_WIDTH:0]  fifolvl_count_o,
  output logic                    fifolvl_ovf_o,
  output logic                    fifolvl_udf_o
);

  localparam int DEPTH = 1 << ADDRESS_WIDTH;

  typedef logic [ADDRESS_WIDTH-1:0] ptr_t;
  typedef logic [ADDRESS_WIDTH:0]   cnt_t;
  typedef logic [DATA_WIDTH-1:0]    word_t;

  localparam ptr_t PTR_ONE    = ptr_t'(1);
  localparam cnt_t CNT_ONE    = cnt_t'(1);
  localparam cnt_t DEPTH_CNT  = cnt_t'(DEPTH);
  localparam cnt_t AFULL_CNT  = cnt_t'(AFULL_LEVEL);
  localparam cnt_t AEMPTY_CNT = cnt_t'(AEMPTY_LEVEL);

  word_t mem_q [DEPTH];

  ptr_t  wptr_q,   wptr_d;
  ptr_t  rptr_q,   rptr_d;
  cnt_t  count_q,  count_d;
  word_t rdata_q,  rdata_d;
  logic  rvalid_q, rvalid_d;
  logic  full_q,   full_d;
  logic  empty_q,  empty_d;
  logic  afull_q,  afull_d;
  logic  aempty_q, aempty_d;

  logic rd_acc;
  logic wr_acc;
  logic mem_we;

  always_comb begin
    // NOTE: every signal gets a default first so no path through this block infers a latch.
    wptr_d   = wptr_q;
    rptr_d   = rptr_q;
    count_d  = count_q;
    rdata_d  = rdata_q;
    rvalid_d = 1'b0;

    // A read frees a slot this cycle, so a write into a full FIFO is still accepted alongside it.
    rd_acc = fifolvl_read_i & ~empty_q;
    wr_acc = fifolvl_write_i & (~full_q | rd_acc);
    mem_we = wr_acc & ~fifolvl_flush_i;

    if (fifolvl_flush_i) begin
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
    end else begin
      rvalid_d = rd_acc;
      if (wr_acc) wptr_d = wptr_q + PTR_ONE;
      if (rd_acc) begin
        rptr_d  = rptr_q + PTR_ONE;
        rdata_d = mem_q[rptr_q];
      end
      case ({wr_acc, rd_acc})
        2'b10:   count_d = count_q + CNT_ONE;
        2'b01:   count_d = count_q - CNT_ONE;
        default: count_d = count_q;
      endcase
    end

    // Flags are computed from the next count so they change on the same edge as the count itself.
    full_d   = (count_d == DEPTH_CNT);
    empty_d  = (count_d == '0);
    afull_d  = (count_d >= AFULL_CNT);
    aempty_d = (count_d <= AEMPTY_CNT);
  end

  always_ff @(posedge fifolvl_clk_i or negedge fifolvl_rstn_i) begin
    if (!fifolvl_rstn_i) begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      wptr_q   <= '0;
      rptr_q   <= '0;
      count_q  <= '0;
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      afull_q  <= 1'b0;
      aempty_q <= 1'b1;
    end else begin
      wptr_q   <= wptr_d;
      rptr_q   <= rptr_d;
      count_q  <= count_d;
      rdata_q  <= rdata_d;
      rvalid_q <= rvalid_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
      afull_q  <= afull_d;
      aempty_q <= aempty_d;
    end
  end

  // NOTE: storage has no reset; stale words are unreachable because the pointers and count are reset.
  always_ff @(posedge fifolvl_clk_i) begin
    if (mem_we) mem_q[wptr_q] <= fifolvl_wdata_i;
  end

`ifdef FIFO_LEVEL_ERR_EN
  logic ovf_q, ovf_d;
  logic udf_q, udf_d;

  always_comb begin
    ovf_d = ovf_q;
    udf_d = udf_q;
    if (fifolvl_flush_i) begin
      ovf_d = 1'b0;
      udf_d = 1'b0;
    end else begin
      if (fifolvl_write_i & full_q & ~rd_acc) ovf_d = 1'b1;
      if (fifolvl_read_i & empty_q)           udf_d = 1'b1;
    end
  end

  always_ff @(posedge fifolvl_clk_i or negedge fifolvl_rstn_i) begin
    if (!fifolvl_rstn_i) begin
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
      udf_q <= udf_d;
    end
  end

  assign fifolvl_ovf_o = ovf_q;
  assign fifolvl_udf_o = udf_q;
`else
  assign fifolvl_ovf_o = 1'b0;
  assign fifolvl_udf_o = 1'b0;
`endif

  assign fifolvl_rdata_o  = rdata_q;
  assign fifolvl_rvalid_o = rvalid_q;
  assign fifolvl_full_o   = full_q;
  assign fifolvl_empty_o  = empty_q;
  assign fifolvl_afull_o  = afull_q;
  assign fifolvl_aempty_o = aempty_q;
  assign fifolvl_count_o  = count_q;

endmodule

// File: tb/tb_fifo_level.sv
// Self-checking bench for fifo_level: vector table, directed corner sequences and random traffic,
// all compared against a queue-based reference model.
module tb_fifo_level;

  localparam int AW    = 4;
  localparam int DW    = 32;
  localparam int DEPTH = 16;
  localparam int AFULL = 14;
  localparam int AEMPTY = 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          flush, write, read;
  logic [DW-1:0] wdata;
  logic [DW-1:0] rdata;
  logic          rvalid, full, empty, afull, aempty, ovf, udf;
  logic [AW:0]   count;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [DW-1:0] mq [$];
  logic [DW-1:0] m_rdata;
  logic          m_rvalid;
  logic          m_ovf;
  logic          m_udf;

  typedef struct {
    logic          flush;
    logic          wr;
    logic          rd;
    logic [DW-1:0] wdata;
    int            exp_count;
    logic          exp_rvalid;
    logic [DW-1:0] exp_rdata;
  } vec_t;

  vec_t vecs [10];

  fifo_level #(
    .ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .AFULL_LEVEL(AFULL), .AEMPTY_LEVEL(AEMPTY)
  ) dut (
    .fifolvl_clk_i    (clk),
    .fifolvl_rstn_i   (rst_n),
    .fifolvl_flush_i  (flush),
    .fifolvl_write_i  (write),
    .fifolvl_wdata_i  (wdata),
    .fifolvl_read_i   (read),
    .fifolvl_rdata_o  (rdata),
    .fifolvl_rvalid_o (rvalid),
    .fifolvl_full_o   (full),
    .fifolvl_empty_o  (empty),
    .fifolvl_afull_o  (afull),
    .fifolvl_aempty_o (aempty),
    .fifolvl_count_o  (count),
    .fifolvl_ovf_o    (ovf),
    .fifolvl_udf_o    (udf)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_rdata  = '0;
    m_rvalid = 1'b0;
    m_ovf    = 1'b0;
    m_udf    = 1'b0;
  endtask

  task automatic model_step(input logic f, input logic w, input logic r, input logic [DW-1:0] d);
    bit rd, wr;
    int n;
    n = mq.size();
    if (f) begin
      mq.delete();
      m_rvalid = 1'b0;
      m_ovf    = 1'b0;
      m_udf    = 1'b0;
    end else begin
      rd = r && (n != 0);
      wr = w && ((n < DEPTH) || rd);
`ifdef FIFO_LEVEL_ERR_EN
      if (w && (n == DEPTH) && !rd) m_ovf = 1'b1;
      if (r && (n == 0))            m_udf = 1'b1;
`endif
      if (rd) m_rdata = mq.pop_front();
      m_rvalid = rd;
      if (wr) mq.push_back(d);
    end
  endtask

  task automatic check_all();
    int n;
    n = mq.size();
    check("count",  32'(count),  32'(n));
    check("empty",  32'(empty),  32'(n == 0));
    check("full",   32'(full),   32'(n == DEPTH));
    check("afull",  32'(afull),  32'(n >= AFULL));
    check("aempty", 32'(aempty), 32'(n <= AEMPTY));
    check("rvalid", 32'(rvalid), 32'(m_rvalid));
    check("rdata",  rdata,       m_rdata);
    check("ovf",    32'(ovf),    32'(m_ovf));
    check("udf",    32'(udf),    32'(m_udf));
  endtask

  // Drive one cycle of inputs, clock it, then compare every output 1 ns after the edge.
  task automatic cycle(input logic f, input logic w, input logic r, input logic [DW-1:0] d);
    flush = f;
    write = w;
    read  = r;
    wdata = d;
    @(posedge clk);
    #1;
    model_step(f, w, r, d);
    check_all();
    flush = 1'b0;
    write = 1'b0;
    read  = 1'b0;
  endtask

  initial begin
    vecs[0] = '{1'b0, 1'b1, 1'b0, 32'h11, 1, 1'b0, 32'h00};
    vecs[1] = '{1'b0, 1'b1, 1'b0, 32'h22, 2, 1'b0, 32'h00};
    vecs[2] = '{1'b0, 1'b0, 1'b1, 32'h00, 1, 1'b1, 32'h11};
    vecs[3] = '{1'b0, 1'b1, 1'b1, 32'h33, 1, 1'b1, 32'h22};
    vecs[4] = '{1'b0, 1'b0, 1'b0, 32'h00, 1, 1'b0, 32'h22};
    vecs[5] = '{1'b0, 1'b0, 1'b1, 32'h00, 0, 1'b1, 32'h33};
    vecs[6] = '{1'b0, 1'b0, 1'b1, 32'h00, 0, 1'b0, 32'h33};
    vecs[7] = '{1'b0, 1'b1, 1'b1, 32'h55, 1, 1'b0, 32'h33};
    vecs[8] = '{1'b0, 1'b0, 1'b1, 32'h00, 0, 1'b1, 32'h55};
    vecs[9] = '{1'b1, 1'b1, 1'b0, 32'h66, 0, 1'b0, 32'h55};

    rst_n = 1'b0;
    flush = 1'b0;
    write = 1'b0;
    read  = 1'b0;
    wdata = '0;
    model_reset();
    #12;
    check_all();
    rst_n = 1'b1;

    // Vector table: mixed single ops, read+write at empty and mid-level, flush with write
    for (int i = 0; i < 10; i++) begin
      cycle(vecs[i].flush, vecs[i].wr, vecs[i].rd, vecs[i].wdata);
      check($sformatf("vec%0d_count", i),  32'(count),  32'(vecs[i].exp_count));
      check($sformatf("vec%0d_rvalid", i), 32'(rvalid), 32'(vecs[i].exp_rvalid));
      check($sformatf("vec%0d_rdata", i),  rdata,       vecs[i].exp_rdata);
    end

    // Fill to full, then a dropped write
    for (int i = 0; i < DEPTH; i++) begin
      cycle(1'b0, 1'b1, 1'b0, 32'h100 + 32'(i));
      check("fill_aempty", 32'(aempty), 32'(i + 1 <= 2));
      check("fill_afull",  32'(afull),  32'(i + 1 >= 14));
    end
    check("fill_full", 32'(full), 32'd1);
    cycle(1'b0, 1'b1, 1'b0, 32'hDEAD);
    check("drop_count", 32'(count), 32'd16);
`ifdef FIFO_LEVEL_ERR_EN
    check("drop_ovf", 32'(ovf), 32'd1);
`endif

    // Drain in order, then an ignored read
    for (int i = 0; i < DEPTH; i++) begin
      cycle(1'b0, 1'b0, 1'b1, '0);
      check("drain_rvalid", 32'(rvalid), 32'd1);
      check("drain_rdata",  rdata,       32'h100 + 32'(i));
    end
    check("drain_empty", 32'(empty), 32'd1);
    cycle(1'b0, 1'b0, 1'b1, '0);
    check("empty_rd_rvalid", 32'(rvalid), 32'd0);
`ifdef FIFO_LEVEL_ERR_EN
    check("empty_rd_udf", 32'(udf), 32'd1);
`endif
    cycle(1'b1, 1'b0, 1'b0, '0);
    check("flush_clr_ovf", 32'(ovf), 32'd0);
    check("flush_clr_udf", 32'(udf), 32'd0);

    // Pointer wrap with alternating write/read pairs
    for (int i = 0; i < 40; i++) begin
      cycle(1'b0, 1'b1, 1'b0, 32'hA0 + 32'(i));
      cycle(1'b0, 1'b0, 1'b1, '0);
      check("wrap_rdata", rdata, 32'hA0 + 32'(i));
    end

    // Simultaneous read+write at full: old head out, new word last
    for (int i = 0; i < DEPTH; i++) cycle(1'b0, 1'b1, 1'b0, 32'h200 + 32'(i));
    cycle(1'b0, 1'b1, 1'b1, 32'h77);
    check("full_rw_count", 32'(count), 32'd16);
    check("full_rw_rdata", rdata,      32'h200);
    for (int i = 0; i < DEPTH; i++) cycle(1'b0, 1'b0, 1'b1, '0);
    check("full_rw_last", rdata, 32'h77);

    // Flush at count 9 with a concurrent write
    for (int i = 0; i < 9; i++) cycle(1'b0, 1'b1, 1'b0, 32'h300 + 32'(i));
    cycle(1'b1, 1'b1, 1'b0, 32'h399);
    check("flush9_count", 32'(count), 32'd0);
    check("flush9_empty", 32'(empty), 32'd1);
    cycle(1'b0, 1'b1, 1'b0, 32'hBEEF);
    cycle(1'b0, 1'b0, 1'b1, '0);
    check("post_flush_rdata", rdata, 32'hBEEF);
    cycle(1'b0, 1'b0, 1'b1, '0);
    check("post_flush_only", 32'(rvalid), 32'd0);

    // Random traffic against the model
    for (int i = 0; i < 400; i++) begin
      cycle(($urandom_range(0, 39) == 0), ($urandom_range(0, 99) < 55),
            ($urandom_range(0, 99) < 50), $urandom);
    end

    // Async reset between edges at count 7
    cycle(1'b1, 1'b0, 1'b0, '0);
    for (int i = 0; i < 7; i++) cycle(1'b0, 1'b1, 1'b0, 32'h400 + 32'(i));
    cycle(1'b0, 1'b1, 1'b1, 32'h407);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all();
    check("async_rst_count", 32'(count), 32'd0);
    #3;
    rst_n = 1'b1;
    cycle(1'b0, 1'b1, 1'b0, 32'h500);
    cycle(1'b0, 1'b0, 1'b1, '0);
    check("after_rst_rdata", rdata, 32'h500);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
